// File: rtl/pow_seq_unit.sv
// Sequential square-and-multiply integer power unit (base ** exp mod 2^WIDTH) with valid/ready handshakes.
// Optional macro POW_SEQ_UNIT_UNDEF_FLAG_EN adds out_undef, flagging 0 ** negative exponent.
module pow_seq_unit #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_base,
  input  logic [WIDTH-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
`ifdef POW_SEQ_UNIT_UNDEF_FLAG_EN
  ,
  output logic             out_undef
`endif
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [IDX_W-1:0] r_idx;
  logic             w_accept;
  logic             w_neg_exp;
  logic             w_last;
  logic [WIDTH-1:0] w_special;
  logic [WIDTH-1:0] w_sq;
  logic [WIDTH-1:0] w_mul;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_neg_exp = SIGNED && in_exp[WIDTH-1];
  assign w_last    = (r_idx == '0);

  // Products are evaluated in a WIDTH-bit context, so only the low bits survive.
  assign w_sq      = r_acc * r_acc;
  assign w_mul     = w_sq * r_base;
  assign w_acc_nxt = r_exp[r_idx] ? w_mul : w_sq;

  always_comb begin
    w_special = '0;
    if (in_base == WIDTH'(1))
      w_special = WIDTH'(1);
    else if (&in_base)
      w_special = in_exp[0] ? '1 : WIDTH'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          w_state_nxt = w_neg_exp ? DONE : CALC;
      end
      CALC: begin
        if (w_last)
          w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_base   <= '0;
      r_exp    <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_base <= in_base;
      r_exp  <= in_exp;
      r_acc  <= WIDTH'(1);
      r_idx  <= IDX_W'(WIDTH - 1);
      if (w_neg_exp)
        r_result <= w_special;
    end else if (r_state == CALC) begin
      r_acc <= w_acc_nxt;
      r_idx <= r_idx - 1'b1;
      if (w_last)
        r_result <= w_acc_nxt;
    end
  end

  assign out_result = r_result;

`ifdef POW_SEQ_UNIT_UNDEF_FLAG_EN
  logic r_undef;

  // Captured at acceptance and held until the next operation is taken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_undef <= 1'b0;
    else if (w_accept)
      r_undef <= w_neg_exp && (in_base == '0);
  end

  assign out_undef = r_undef;
`endif

endmodule

// File: tb/tb_pow_seq_unit.sv
// Directed self-checking bench for pow_seq_unit: one signed and one unsigned instance, WIDTH=8.
module tb_pow_seq_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid   [2];
  logic         in_ready   [2];
  logic [W-1:0] in_base    [2];
  logic [W-1:0] in_exp     [2];
  logic         out_valid  [2];
  logic         out_ready  [2];
  logic [W-1:0] out_result [2];
`ifdef POW_SEQ_UNIT_UNDEF_FLAG_EN
  logic         out_undef  [2];
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pow_seq_unit #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid[0]),
    .in_ready   (in_ready[0]),
    .in_base    (in_base[0]),
    .in_exp     (in_exp[0]),
    .out_valid  (out_valid[0]),
    .out_ready  (out_ready[0]),
    .out_result (out_result[0])
`ifdef POW_SEQ_UNIT_UNDEF_FLAG_EN
    ,
    .out_undef  (out_undef[0])
`endif
  );

  pow_seq_unit #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid[1]),
    .in_ready   (in_ready[1]),
    .in_base    (in_base[1]),
    .in_exp     (in_exp[1]),
    .out_valid  (out_valid[1]),
    .out_ready  (out_ready[1]),
    .out_result (out_result[1])
`ifdef POW_SEQ_UNIT_UNDEF_FLAG_EN
    ,
    .out_undef  (out_undef[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  // Issue one operation on instance s, measure latency, optionally stall the result, then consume it.
  task automatic run_op(input int s, input logic [W-1:0] b, input logic [W-1:0] e,
                        input logic [W-1:0] exp_res, input int exp_lat, input int hold,
                        input string tag, output logic [W-1:0] res);
    int   k;
    bit   seen;
    bit   busy_bad;
    bit   stable_bad;
    logic [W-1:0] first;
    k = 0;
    while (in_ready[s] !== 1'b1 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    in_base[s]  = b;
    in_exp[s]   = e;
    in_valid[s] = 1'b1;
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
    k = 1; seen = 0; busy_bad = 0;
    while (!seen && k <= 40) begin
      if (out_valid[s] === 1'b1) seen = 1;
      else begin
        if (in_ready[s] !== 1'b0) busy_bad = 1;
        @(posedge clk); #1; k++;
      end
    end
    check({tag, "_lat"}, seen ? k : 0, exp_lat);
    check({tag, "_busy"}, {31'd0, busy_bad | in_ready[s]}, 32'd0);
    check({tag, "_res"}, {24'd0, out_result[s]}, {24'd0, exp_res});
    res = out_result[s];
    first = out_result[s];
    stable_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_valid[s] !== 1'b1 || out_result[s] !== first) stable_bad = 1;
    end
    if (hold > 0)
      check({tag, "_hold"}, {31'd0, stable_bad}, 32'd0);
    out_ready[s] = 1'b1;
    @(posedge clk); #1;
    out_ready[s] = 1'b0;
    check({tag, "_drain"}, {30'd0, out_valid[s], in_ready[s]}, 32'd1);
  endtask

  logic [W-1:0] r0, r1, r2, r3, rr;

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_base[i] = '0; in_exp[i] = '0; out_ready[i] = 1'b0;
    end
    #12;
    check("rst_state", {22'd0, out_valid[0], in_ready[0], out_result[0]}, 32'h100);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // Negative-exponent special cases, signed instance.
    run_op(0, 8'h01, 8'hFE, 8'h01, 1, 0, "p1_m2", r0);
    run_op(0, 8'h02, 8'hFE, 8'h00, 1, 0, "p2_m2", r1);
    run_op(0, 8'hFE, 8'hFD, 8'h00, 1, 0, "m2_m3", r2);
    run_op(0, 8'hFF, 8'hFD, 8'hFF, 1, 0, "m1_m3", r3);
    check("special_cat", {r0, r1, r2, r3}, 32'h010000FF);
    run_op(0, 8'hFF, 8'hFE, 8'h01, 1, 0, "m1_m2", rr);

    // Normal square-and-multiply path.
    run_op(0, 8'h03, 8'h05, 8'hF3, 9, 0, "p3_p5", rr);
    run_op(0, 8'hFD, 8'h03, 8'hE5, 9, 0, "m3_p3", rr);
    run_op(0, 8'h02, 8'h08, 8'h00, 9, 0, "p2_p8", rr);
    run_op(0, 8'h00, 8'h00, 8'h01, 9, 0, "z_z", rr);
    run_op(0, 8'h00, 8'h05, 8'h00, 9, 0, "z_p5", rr);
    run_op(0, 8'h07, 8'h00, 8'h01, 9, 0, "p7_z", rr);

    // Unsigned instance: top exponent bit is an ordinary bit.
    run_op(1, 8'hFE, 8'h02, 8'h04, 9, 0, "u_fe_2", rr);
    run_op(1, 8'h02, 8'hFF, 8'h00, 9, 0, "u_2_ff", rr);
    run_op(1, 8'h03, 8'h81, 8'h03, 9, 0, "u_3_81", rr);

    // Backpressure on the result.
    run_op(0, 8'h05, 8'h02, 8'h19, 9, 5, "bp", rr);
    check("bp_result_kept", {24'd0, out_result[0]}, 32'h19);

    // Asynchronous reset in the middle of a calculation.
    in_base[0] = 8'h03; in_exp[0] = 8'h05; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_flags", {30'd0, out_valid[0], in_ready[0]}, 32'd1);
    check("arst_result", {24'd0, out_result[0]}, 32'd0);
    @(negedge clk); resetn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("arst_no_result", {31'd0, out_valid[0]}, 32'd0);
    run_op(0, 8'h02, 8'h03, 8'h08, 9, 0, "after_rst", rr);

`ifdef POW_SEQ_UNIT_UNDEF_FLAG_EN
    run_op(0, 8'h00, 8'hFF, 8'h00, 1, 0, "undef_z", rr);
    check("undef_flag_set", {31'd0, out_undef[0]}, 32'd1);
    run_op(0, 8'h01, 8'hFF, 8'h01, 1, 0, "undef_one", rr);
    check("undef_flag_clr", {31'd0, out_undef[0]}, 32'd0);
    run_op(1, 8'h00, 8'hFF, 8'h00, 9, 0, "undef_u", rr);
    check("undef_unsigned", {31'd0, out_undef[1]}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pow_seq_unit.md
Name: pow_seq_unit

Overview:
- Parametrised, sequential integer power unit: computes base ** exponent with the language's integer-power semantics, including signed negative-exponent rules.
- Successor to the constant-folded power checks in the verilatortest suite. Generalises them to arbitrary width, signed or unsigned mode, a valid/ready handshake and a square-and-multiply datapath.
- Used as a synthesisable, simulator-comparable reference for power-operator regression tests.

Parameters:
- WIDTH, 8, width of base, exponent and result (>=2).
- SIGNED, 1, 1 = operands and result are two's-complement signed; 0 = all unsigned.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  unit can accept operands.
- in_base  input  WIDTH  base operand.
- in_exp  input  WIDTH  exponent operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  base ** exponent, truncated to WIDTH bits.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, in_ready=1, out_valid=0, out_result=0, internal accumulator/counter cleared.
- Reset asserted mid-calculation or while holding a result: the operation is abandoned immediately and no result is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. Accept on in_valid&&in_ready at edge t0, then latch base and exponent.
  - Special case (SIGNED=1 and in_exp MSB=1, i.e. negative exponent): go to DONE with the special result.
  - Otherwise go to CALC with acc=1 and bit index=WIDTH-1.
- Special results for a negative exponent:
  - base==1 -> 1.
  - base==-1 -> all-ones (-1) if exp[0]=1, else 1.
  - base==0 -> 0 (language result is undefined; see optional feature).
  - any other base -> 0.
- CALC: one exponent bit per cycle, MSB first.
  - Each cycle: acc = acc*acc mod 2^WIDTH; then if the bit is set, acc = acc*base mod 2^WIDTH.
  - Exactly WIDTH cycles in CALC, then DONE.
- Arithmetic: only the low WIDTH bits of each product are kept. Modular results are identical for signed and unsigned operands, so SIGNED affects only the negative-exponent decode.
- 0**0 = 1. Any base ** 0 = 1. 0**positive = 0.
- Latency: the first edge sampling out_valid=1 is t0+WIDTH+1 for normal operation and t0+1 for the special case.
- DONE: out_valid=1, out_result=acc, in_ready=0.
  - out_result and out_valid are held stable until out_valid&&out_ready.
  - On that edge: return to IDLE, out_valid=0. out_result keeps its last value.
- No overlap: a new operand is never accepted in the same cycle a result is consumed. in_ready rises the cycle after consumption.
- in_valid while busy is ignored (in_ready=0). Operands must be held by the producer.
- out_ready high while out_valid=0 has no effect.

Optional Feature:
- Macro POW_SEQ_UNIT_UNDEF_FLAG_EN.
- Defined:
  - Adds output port out_undef (1 bit).
  - Set to 1 with out_valid when the accepted operation was 0 ** negative exponent (SIGNED=1 only); 0 for all other operations.
  - Held with out_result; reset value 0.
- Undefined:
  - The port is absent.
  - 0 ** negative still returns 0 with no indication.

Test Plan:
- WIDTH=8, SIGNED=1: issue 1**-2, 2**-2, -2**-3, -1**-3 back to back -> results 8'h01, 8'h00, 8'h00, 8'hFF. Each out_valid occurs 1 edge after acceptance. Concatenated, the results form 32'h010000FF.
- WIDTH=8, SIGNED=1: 3**5 -> 8'hF3 and -3**3 -> 8'hE5. out_valid occurs exactly 9 edges after the accepting edge. in_ready=0 throughout.
- WIDTH=8: 2**8 -> 8'h00 (wrap) and 0**0 -> 8'h01. With SIGNED=0: 8'hFE**8'h02 -> 8'h04 and 8'h02**8'hFF -> 8'h00 (no special-case path, 9-edge latency).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_result/out_valid stable. Raise out_ready -> out_valid falls next edge, and in_ready rises.
- Drop resetn asynchronously mid-CALC (cycle 4) -> out_valid=0 and in_ready=1 immediately. A following 2**3 returns 8'h08 with normal latency.
- With POW_SEQ_UNIT_UNDEF_FLAG_EN defined: 0**-1 -> out_result=0, out_undef=1. Next, 1**-1 -> out_result=1, out_undef=0.
